tv_streamer: RTL and testbench
==============================

TV_STREAMER -- requirements
Module: tv_streamer

Interface
REQ-001 SHALL have parameter W, default tb_pkg::W (32 at HIGH_PERF=0), meaning the data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the test-vector memory word-address width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to stream one vector.
REQ-006 SHALL have port mode, input, 2, the operation (KEYGEN_MODE/SIGN_MODE/VERIFY_MODE), sampled with start.
REQ-007 SHALL have port base_addr, input, ADDR_W, the first memory word of the vector, sampled with start.
REQ-008 SHALL have port msg_len_bits, input, MSG_LEN_SIZE, the message length in bits, sampled with start.
REQ-009 SHALL have port mem_en, output, 1, the memory read strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W, the memory read address.
REQ-011 SHALL have port mem_rdata, input, W, the read data, valid exactly 1 cycle after mem_en.
REQ-012 SHALL have port dout, output, W, the streamed word to the DUT.
REQ-013 SHALL have port dout_valid, output, 1, qualifying dout.
REQ-014 SHALL have port dout_ready, input, 1, DUT acceptance.
REQ-015 SHALL have port dout_last, output, 1, marking the final word of the vector.
REQ-016 SHALL have port seg_id, output, 4, the segment of the current dout.
REQ-017 SHALL have ports busy, done and err, each output, 1; done and err are one-cycle pulses.

Function
REQ-018 Segment order SHALL be: KEYGEN = SEED; SIGN = RHO, MSG_LEN, MSG, K, TR, S1, S2, T0; VERIFY = RHO, C, Z, H, T1, MSG_LEN, MSG.
REQ-019 Segment word counts SHALL be RHO/K/TR/C/SEED = SEED_WORDS_NUM; S1/S2/T0/T1/Z/H = the corresponding *_WORDS_NUM; MSG = ceil(msg_len_bits/W); MSG_LEN = 1.
REQ-020 The MSG_LEN word SHALL be generated internally as msg_len_bits zero-extended to W and SHALL consume no memory address.
REQ-021 All other words SHALL be read from consecutive addresses starting at base_addr, in segment order.
REQ-022 A segment of length 0 (MSG when msg_len_bits = 0) SHALL be skipped with no idle cycle.
REQ-023 FSM SHALL have states IDLE, LOAD, STREAM and FLUSH.
  - IDLE -> LOAD on start with a valid mode.
  - LOAD (1 cycle: latch inputs, select the first segment) -> STREAM.
  - STREAM -> FLUSH after the last memory read is issued.
  - FLUSH -> IDLE when the last word is accepted; done pulses in that same cycle.
REQ-024 Reads SHALL be prefetched into a 2-entry output FIFO.
  - mem_en asserts only when (FIFO occupancy + reads outstanding) < 2.
  - Sustained throughput SHALL be 1 word/cycle while dout_ready = 1.
REQ-025 First dout_valid SHALL occur no later than 3 cycles after start.
REQ-026 Handshake: a transfer occurs when dout_valid & dout_ready; dout, dout_last and seg_id SHALL stay stable while dout_valid & !dout_ready.
REQ-027 dout_last SHALL be 1 only on the final word of the vector.
REQ-028 start while busy SHALL be ignored.
REQ-029 start with mode = 2'b11 SHALL be ignored and SHALL pulse err on the following cycle.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_W without error.
REQ-031 busy SHALL be 1 from the cycle after an accepted start until the cycle after done.

Reset
REQ-032 On rst_n = 0 at a clk edge:
  - FSM -> IDLE; FIFO emptied; outstanding reads discarded.
  - mem_en, dout_valid, dout_last, busy, done and err SHALL be 0; dout, mem_addr and seg_id SHALL be 0.
REQ-033 Reset mid-vector SHALL abort the vector without a done pulse, and read data returned after reset SHALL be dropped.

Structure
REQ-034 Segment-ID enum, per-mode segment tables and segment word counts SHALL live in a shared package alongside tb_pkg sizes and mode constants.
REQ-035 The 2-entry FIFO SHALL be a sub-module named tv_skid_fifo.

Verification (SEC_LEVEL=2, W=32)
REQ-036 KEYGEN, base 0x0100, dout_ready = 1 -> 8 words from 0x0100..0x0107, contiguous valid, dout_last on the 8th, done once.
REQ-037 SIGN, msg_len_bits = 33 -> 635 words; word 9 = 0x00000021; MSG = 2 words; S1 begins at address base+26.
REQ-038 VERIFY, msg_len_bits = 0 -> the MSG segment is absent, the MSG_LEN word (value 0) is last with dout_last, and the total is 1030 words.
REQ-039 Random dout_ready toggling during SIGN -> no word lost or duplicated (scoreboard against memory), and outputs stable while stalled.
REQ-040 Checks for illegal and aborted requests:
  - start with mode = 2'b11 -> err pulse, busy stays 0.
  - start during busy -> ignored.
  - rst_n low at word 300 of VERIFY -> all outputs 0, no done; the next KEYGEN runs correctly.

Source files
------------

// File: rtl/tv_streamer_pkg.sv
// Shared sizes, operation codes, segment IDs and per-mode segment tables
// for the test-vector streamer (Dilithium SEC_LEVEL 2 sizing).
package tb_pkg;

    localparam int unsigned HIGH_PERF    = 0;
    localparam int unsigned W            = (HIGH_PERF == 0) ? 32 : 64;
    localparam int unsigned MSG_LEN_SIZE = 16;

    localparam int unsigned SEED_WORDS_NUM = 256 / W;
    localparam int unsigned S1_WORDS_NUM   = 3072 / W;
    localparam int unsigned S2_WORDS_NUM   = 3072 / W;
    localparam int unsigned T0_WORDS_NUM   = 13312 / W;
    localparam int unsigned T1_WORDS_NUM   = 10240 / W;
    localparam int unsigned Z_WORDS_NUM    = 18432 / W;
    localparam int unsigned H_WORDS_NUM    = 3744 / W;

    localparam logic [1:0] KEYGEN_MODE = 2'd0;
    localparam logic [1:0] SIGN_MODE   = 2'd1;
    localparam logic [1:0] VERIFY_MODE = 2'd2;

endpackage

package tv_streamer_pkg;
    import tb_pkg::*;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_e;

    typedef enum logic [3:0] {
        SEG_SEED    = 4'd0,
        SEG_RHO     = 4'd1,
        SEG_MSG_LEN = 4'd2,
        SEG_MSG     = 4'd3,
        SEG_K       = 4'd4,
        SEG_TR      = 4'd5,
        SEG_S1      = 4'd6,
        SEG_S2      = 4'd7,
        SEG_T0      = 4'd8,
        SEG_C       = 4'd9,
        SEG_Z       = 4'd10,
        SEG_H       = 4'd11,
        SEG_T1      = 4'd12
    } seg_e;

    localparam seg_e SIGN_SEGS [0:7] = '{SEG_RHO, SEG_MSG_LEN, SEG_MSG, SEG_K,
                                         SEG_TR, SEG_S1, SEG_S2, SEG_T0};
    localparam seg_e VERIFY_SEGS [0:6] = '{SEG_RHO, SEG_C, SEG_Z, SEG_H,
                                           SEG_T1, SEG_MSG_LEN, SEG_MSG};

    function automatic logic [3:0] num_segs(input logic [1:0] mode);
        case (mode)
            SIGN_MODE:   return 4'd8;
            VERIFY_MODE: return 4'd7;
            default:     return 4'd1;
        endcase
    endfunction

    // Indices past the end of a table fall back to SEG_SEED; never streamed.
    function automatic seg_e seg_at(input logic [1:0] mode, input logic [3:0] idx);
        case (mode)
            SIGN_MODE:   return (idx < 4'd8) ? SIGN_SEGS[idx[2:0]] : SEG_SEED;
            VERIFY_MODE: return (idx < 4'd7) ? VERIFY_SEGS[idx[2:0]] : SEG_SEED;
            default:     return SEG_SEED;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] seg_words(input seg_e seg,
                                                   input logic [CNT_W-1:0] msg_words);
        case (seg)
            SEG_MSG_LEN: return CNT_W'(1);
            SEG_MSG:     return msg_words;
            SEG_S1:      return CNT_W'(S1_WORDS_NUM);
            SEG_S2:      return CNT_W'(S2_WORDS_NUM);
            SEG_T0:      return CNT_W'(T0_WORDS_NUM);
            SEG_T1:      return CNT_W'(T1_WORDS_NUM);
            SEG_Z:       return CNT_W'(Z_WORDS_NUM);
            SEG_H:       return CNT_W'(H_WORDS_NUM);
            default:     return CNT_W'(SEED_WORDS_NUM);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] total_words(input logic [1:0] mode,
                                                     input logic [CNT_W-1:0] msg_words);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i) < num_segs(mode)) begin
                sum = sum + seg_words(seg_at(mode, 4'(i)), msg_words);
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/tv_skid_fifo.sv
// Two-entry output FIFO holding prefetched words ahead of the DUT handshake.
module tv_skid_fifo #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          rd_q;
    logic          wr_q;
    logic [1:0]    cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/tv_streamer.sv
// Streams one test vector (segments from memory plus a generated MSG_LEN word)
// to a DUT over a valid/ready handshake, prefetching through a 2-entry FIFO.
module tv_streamer
    import tv_streamer_pkg::*;
#(
    parameter int unsigned W      = tb_pkg::W,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [tb_pkg::MSG_LEN_SIZE-1:0] msg_len_bits,
    output logic                            mem_en,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic [W-1:0]                    mem_rdata,
    output logic [W-1:0]                    dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            dout_last,
    output logic [3:0]                      seg_id,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int unsigned ML_W = tb_pkg::MSG_LEN_SIZE;
    localparam int unsigned DW   = W + 5;

    function automatic logic [CNT_W-1:0] ceil_words(input logic [ML_W-1:0] bits);
        logic [ML_W:0] t;
        t = {1'b0, bits} + (ML_W+1)'(W - 1);
        return CNT_W'(t / (ML_W+1)'(W));
    endfunction

    state_e            state_q;
    logic [1:0]        mode_q;
    logic [ML_W-1:0]   msg_len_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  seg_rem_q, seg_rem_d;
    logic [CNT_W-1:0]  tot_rem_q, tot_rem_d;
    logic              out_q, out_int_q, out_last_q;
    seg_e              out_seg_q;
    logic              err_q;

    logic              start_ok;
    seg_e              cur_seg;
    logic              is_int;
    logic              issue;
    logic              last_issue;
    logic              pop;
    logic [2:0]        occ;
    logic [3:0]        nxt1, nxt2;
    logic [CNT_W-1:0]  msgw;
    logic [DW-1:0]     fifo_din, fifo_dout;
    logic              fifo_valid;
    logic [1:0]        fifo_cnt;

    assign start_ok = start && (mode != 2'b11);
    assign cur_seg  = seg_at(mode_q, idx_q);
    assign is_int   = (cur_seg == SEG_MSG_LEN);
    assign pop      = fifo_valid && dout_ready;
    assign occ      = 3'(fifo_cnt) + 3'(out_q);

    // The word leaving this cycle frees its slot, so a full pipe can still issue.
    assign issue      = ((state_q == LOAD) || (state_q == STREAM)) && (occ < (3'd2 + 3'(pop)));
    assign last_issue = issue && (tot_rem_q == CNT_W'(1));

    assign mem_en   = issue && !is_int;
    assign mem_addr = addr_q;

    always_comb begin
        addr_d    = addr_q;
        idx_d     = idx_q;
        seg_rem_d = seg_rem_q;
        tot_rem_d = tot_rem_q;
        nxt1      = idx_q + 4'd1;
        nxt2      = idx_q + 4'd2;
        msgw      = ceil_words(msg_len_q);
        if ((state_q == IDLE) && start_ok) begin
            addr_d    = base_addr;
            idx_d     = '0;
            seg_rem_d = seg_words(seg_at(mode, 4'd0), ceil_words(msg_len_bits));
            tot_rem_d = total_words(mode, ceil_words(msg_len_bits));
        end else if (issue) begin
            tot_rem_d = tot_rem_q - CNT_W'(1);
            if (!is_int) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            if (seg_rem_q == CNT_W'(1)) begin
                // Only MSG can be empty and it never follows another empty segment.
                if ((nxt1 < num_segs(mode_q)) && (seg_words(seg_at(mode_q, nxt1), msgw) != '0)) begin
                    idx_d     = nxt1;
                    seg_rem_d = seg_words(seg_at(mode_q, nxt1), msgw);
                end else begin
                    idx_d     = nxt2;
                    seg_rem_d = seg_words(seg_at(mode_q, nxt2), msgw);
                end
            end else begin
                seg_rem_d = seg_rem_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            msg_len_q  <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            seg_rem_q  <= '0;
            tot_rem_q  <= '0;
            out_q      <= 1'b0;
            out_int_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_seg_q  <= SEG_SEED;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            seg_rem_q  <= seg_rem_d;
            tot_rem_q  <= tot_rem_d;
            out_q      <= issue;
            out_int_q  <= is_int;
            out_last_q <= last_issue;
            out_seg_q  <= cur_seg;
            err_q      <= (state_q == IDLE) && start && (mode == 2'b11);
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        mode_q    <= mode;
                        msg_len_q <= msg_len_bits;
                        state_q   <= LOAD;
                    end
                end
                LOAD:    state_q <= last_issue ? FLUSH : STREAM;
                STREAM:  if (last_issue) state_q <= FLUSH;
                FLUSH:   if (done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_din = {out_last_q, out_seg_q, out_int_q ? W'(msg_len_q) : mem_rdata};

    tv_skid_fifo #(
        .DW (DW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .push_i  (out_q),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign dout       = fifo_dout[W-1:0];
    assign seg_id     = fifo_dout[W+3:W];
    assign dout_last  = fifo_dout[W+4] && fifo_valid;
    assign dout_valid = fifo_valid;
    assign done       = (state_q == FLUSH) && pop && dout_last;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_tv_streamer.sv
// Self-checking bench: table of vectors plus corner-case sequences, scored
// against a segment-list reference model over a random-content memory.
module tb_tv_streamer;
    import tb_pkg::*;
    import tv_streamer_pkg::*;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } wrd_t;

    typedef struct {
        logic [1:0]  md;
        logic [15:0] base;
        logic [15:0] ml;
        bit          rnd;
        int          words;
        int          busy_at;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, start, dout_ready;
    logic [1:0]  mode;
    logic [15:0] base_addr, msg_len_bits;
    logic        mem_en, dout_valid, dout_last, busy, done, err;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata, dout;
    logic [3:0]  seg_id;

    logic [31:0] mem [0:65535];
    wrd_t        exp_q[$];
    wrd_t        rec_q[$];
    vec_t        tbl[7];
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem_en ? mem[mem_addr] : $urandom;

    tv_streamer #(
        .W      (32),
        .ADDR_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .base_addr    (base_addr),
        .msg_len_bits (msg_len_bits),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .seg_id       (seg_id),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic check_reset(input string nm);
        check(nm, 64'({mem_en, dout_valid, dout_last, busy, done, err, dout, mem_addr, seg_id}), 64'd0);
    endtask

    function automatic int seg_cnt(input seg_e s, input logic [15:0] ml);
        case (s)
            SEG_MSG_LEN: return 1;
            SEG_MSG:     return (int'(ml) + 31) / 32;
            SEG_S1:      return S1_WORDS_NUM;
            SEG_S2:      return S2_WORDS_NUM;
            SEG_T0:      return T0_WORDS_NUM;
            SEG_T1:      return T1_WORDS_NUM;
            SEG_Z:       return Z_WORDS_NUM;
            SEG_H:       return H_WORDS_NUM;
            default:     return SEED_WORDS_NUM;
        endcase
    endfunction

    task automatic build_expected(input logic [1:0] md, input logic [15:0] base, input logic [15:0] ml);
        seg_e        segs[$];
        logic [15:0] a;
        wrd_t        w;
        case (md)
            KEYGEN_MODE: segs = '{SEG_SEED};
            SIGN_MODE:   segs = '{SEG_RHO, SEG_MSG_LEN, SEG_MSG, SEG_K, SEG_TR, SEG_S1, SEG_S2, SEG_T0};
            default:     segs = '{SEG_RHO, SEG_C, SEG_Z, SEG_H, SEG_T1, SEG_MSG_LEN, SEG_MSG};
        endcase
        exp_q.delete();
        a = base;
        foreach (segs[i]) begin
            for (int k = 0; k < seg_cnt(segs[i], ml); k++) begin
                w.s = segs[i];
                w.l = 1'b0;
                if (segs[i] == SEG_MSG_LEN) begin
                    w.d = 32'(ml);
                end else begin
                    w.d = mem[a];
                    a   = a + 16'd1;
                end
                exp_q.push_back(w);
            end
        end
        w   = exp_q.pop_back();
        w.l = 1'b1;
        exp_q.push_back(w);
    endtask

    task automatic run_vec(input logic [1:0] md, input logic [15:0] base, input logic [15:0] ml,
                           input bit rnd, input int words, input int busy_at, input int abort_at);
        int          cyc, got, dones, first_v, last_t;
        bit          stall;
        logic [37:0] snap;
        wrd_t        e, r;
        build_expected(md, base, ml);
        rec_q.delete();
        @(negedge clk);
        start = 1'b1; mode = md; base_addr = base; msg_len_bits = ml; dout_ready = 1'b1;
        cyc = 0; got = 0; dones = 0; first_v = -1; last_t = -1; stall = 1'b0; snap = '0;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == busy_at);
            if (start) begin
                mode = SIGN_MODE; base_addr = 16'h7000;
            end
            if (got == abort_at) break;
            dout_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (cyc == 1) check("busy_rise", 64'(busy), 64'd1);
            if (stall) check("stall_hold", 64'({dout_valid, dout_last, seg_id, dout}), 64'(snap));
            if (dout_valid && first_v < 0) first_v = cyc;
            if (done) dones++;
            if (dout_valid && dout_ready) begin
                r = '{dout, seg_id, dout_last};
                rec_q.push_back(r);
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(dout_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("word%0d", got), 64'({r.l, r.s, r.d}), 64'({e.l, e.s, e.d}));
                    check("done_sync", 64'(done), 64'(e.l));
                end
                got++;
                last_t = cyc;
            end
            stall = dout_valid && !dout_ready;
            snap  = {dout_valid, dout_last, seg_id, dout};
            if (done) break;
        end
        if (got == abort_at) begin
            check("abort_no_done", 64'(dones), 64'd0);
            rst_n = 1'b0;
            start = 1'b0;
            @(negedge clk);
            #1 check_reset("abort_reset");
            rst_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                #1 check("abort_drop", 64'({dout_valid, done, busy, mem_en}), 64'd0);
            end
            return;
        end
        check("word_count", 64'(got), 64'(words));
        check("done_count", 64'(dones), 64'd1);
        check("first_valid_le3", 64'(first_v > 0 && first_v <= 3), 64'd1);
        if (!rnd) check("throughput", 64'(last_t - first_v + 1), 64'(words));
        @(negedge clk);
        start = 1'b0;
        #1 check("idle_after", 64'({busy, done, dout_valid}), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; mode = '0; base_addr = '0; msg_len_bits = '0; dout_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;

        tbl[0] = '{KEYGEN_MODE, 16'h0100, 16'd0,     1'b0, 8,    -1};
        tbl[1] = '{KEYGEN_MODE, 16'hFFFC, 16'd0,     1'b1, 8,     4};
        tbl[2] = '{SIGN_MODE,   16'h1000, 16'd33,    1'b1, 635,  -1};
        tbl[3] = '{SIGN_MODE,   16'h1800, 16'd0,     1'b0, 633,  -1};
        tbl[4] = '{VERIFY_MODE, 16'h4000, 16'd100,   1'b1, 1034, -1};
        tbl[5] = '{VERIFY_MODE, 16'hFF00, 16'd0,     1'b0, 1030, -1};
        tbl[6] = '{SIGN_MODE,   16'h0000, 16'd65535, 1'b0, 2681, -1};

        repeat (3) @(negedge clk);
        #1 check_reset("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i].md, tbl[i].base, tbl[i].ml, tbl[i].rnd, tbl[i].words, tbl[i].busy_at, -1);
        end

        run_vec(SIGN_MODE, 16'h2000, 16'd33, 1'b0, 635, -1, -1);
        check("sign_word9", 64'(rec_q[8].d), 64'h21);
        check("sign_s1_data", 64'(rec_q[27].d), 64'(mem[16'h2000 + 16'd26]));
        check("sign_s1_seg", 64'(rec_q[27].s), 64'(SEG_S1));
        n = 0;
        foreach (rec_q[i]) if (rec_q[i].s == SEG_MSG) n++;
        check("sign_msg_words", 64'(n), 64'd2);

        run_vec(VERIFY_MODE, 16'h3000, 16'd0, 1'b0, 1030, -1, -1);
        check("verify_last", 64'({rec_q[rec_q.size()-1].l, rec_q[rec_q.size()-1].s, rec_q[rec_q.size()-1].d}),
              64'({1'b1, SEG_MSG_LEN, 32'd0}));
        n = 0;
        foreach (rec_q[i]) if (rec_q[i].s == SEG_MSG) n++;
        check("verify_no_msg", 64'(n), 64'd0);

        @(negedge clk);
        start = 1'b1; mode = 2'b11;
        @(negedge clk);
        start = 1'b0;
        #1 check("err_pulse", 64'({err, busy}), 64'b10);
        @(negedge clk);
        #1 check("err_clear", 64'({err, busy, mem_en}), 64'd0);

        run_vec(VERIFY_MODE, 16'h5000, 16'd64, 1'b1, 1032, -1, 300);
        run_vec(KEYGEN_MODE, 16'h0500, 16'd0, 1'b0, 8, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
